mdu_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage MIPS pipeline. It sits beside the E-stage ALU and owns the HI/LO register pair. It issues mult/multu/div/divu as fixed-latency multi-cycle operations, services mfhi/mflo/mthi/mtlo, and raises a stall request to the hazard logic while the unit is occupied.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 32 +++
 rtl/mdu_ctrl.sv | 67 ++++++
 tb/tb_mdu_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings, defaults and result constants for the multiply/divide unit (divide ops gated by MDU_DIV_EN)
package mdu_pkg;
   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_t;
   typedef enum logic {IDLE, BUSY} mdu_state_t;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;
   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_LO = 32'h8000_0000;
   localparam logic [31:0] OVF_HI = 32'h0000_0000;
   function automatic logic is_mul(input logic [3:0] op);
      return op == MD_MULT || op == MD_MULTU;
   endfunction
   function automatic logic is_long_op(input logic [3:0] op);
`ifdef MDU_DIV_EN
      return is_mul(op) || op == MD_DIV || op == MD_DIVU;
`else
      return is_mul(op);
`endif
   endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {hi,lo} result for mult/multu and, under MDU_DIV_EN, div/divu
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res
);
   logic [63:0] p_s, p_u;
   assign p_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign p_u = {32'b0, a} * {32'b0, b};
`ifdef MDU_DIV_EN
   logic [31:0] ma, mb, qm, rm;
   logic [63:0] d_s, d_u;
   assign ma = a[31] ? -a : a;
   assign mb = b[31] ? -b : b;
   assign qm = ma / mb;
   assign rm = ma % mb;
   assign d_s = b == '0 ? {a, DIV0_LO} :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {OVF_HI, OVF_LO} :
                {a[31] ? -rm : rm, (a[31] ^ b[31]) ? -qm : qm};
   assign d_u = b == '0 ? {a, DIV0_LO} : {a % b, a / b};
   // select the result for the decoded operation
   always_comb
      res = op == MD_MULT ? p_s : op == MD_MULTU ? p_u : op == MD_DIV ? d_s : op == MD_DIVU ? d_u : '0;
`else
   // select the result for the decoded operation
   always_comb
      res = op == MD_MULT ? p_s : op == MD_MULTU ? p_u : '0;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner and fixed-latency mult/div sequencer with stall request (divide enabled by MDU_DIV_EN)
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op_E,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   input  logic        md_use_D,
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] md_out_E
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   mdu_state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [31:0] hi_pend, lo_pend;
   logic [63:0] res;

   mdu_arith u_arith (.op(md_op_E), .a(A_E), .b(B_E), .res(res));

   assign busy = state == BUSY;

   // issue decode, next state, stall request and HI/LO read mux
   always_comb begin
      start = state == IDLE && is_long_op(md_op_E);
      state_n = start ? BUSY : (state == BUSY && cnt == CW'(1)) ? IDLE : state;
      stall_md = md_use_D & (start | busy);
      md_out_E = md_op_E == MD_MFHI ? HI : md_op_E == MD_MFLO ? LO : '0;
   end

   // state, countdown, pending result capture and architectural HI/LO commit
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         hi_pend <= '0;
         lo_pend <= '0;
         HI <= '0;
         LO <= '0;
      end else begin
         state <= state_n;
         if (start) begin
            cnt <= is_mul(md_op_E) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            hi_pend <= res[63:32];
            lo_pend <= res[31:0];
         end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               HI <= hi_pend;
               LO <= lo_pend;
            end
         end else begin
            if (md_op_E == MD_MTHI) HI <= A_E;
            if (md_op_E == MD_MTLO) LO <= A_E;
         end
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl; expectations follow MDU_DIV_EN
module tb_mdu_ctrl;
   import mdu_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] md_op_E = MD_NONE;
   logic [31:0] A_E = '0;
   logic [31:0] B_E = '0;
   logic md_use_D = 1'b0;
   logic start, busy, stall_md;
   logic [31:0] HI, LO, md_out_E;
   int n_chk = 0;
   int n_err = 0;
   logic [63:0] sb[$];

   mdu_ctrl dut (
      .clk(clk), .reset(reset), .md_op_E(md_op_E), .A_E(A_E), .B_E(B_E), .md_use_D(md_use_D),
      .start(start), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO), .md_out_E(md_out_E)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      longint unsigned ux, uy;
      int da, db;
      x = int'(a);
      y = int'(b);
      ux = 64'(a);
      uy = 64'(b);
      da = int'(a);
      db = int'(b);
      case (op)
         MD_MULT:  return x * y;
         MD_MULTU: return ux * uy;
         MD_DIV:   return b == 0 ? {a, 32'hFFFF_FFFF} :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {32'h0, 32'h8000_0000} :
                          {32'(da % db), 32'(da / db)};
         MD_DIVU:  return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default:  return '0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic use_d, input int abort_at);
      int nb, ns;
      nb = 0;
      md_op_E = op;
      A_E = a;
      B_E = b;
      md_use_D = use_d;
      #1;
      check("start", start, 1);
      ns = int'(stall_md);
      sb.push_back(model(op, a, b));
      for (int i = 0; i < 40; i++) begin
         step();
         md_op_E = MD_NONE;
         if (!busy) break;
         check("start_low", start, 0);
         nb++;
         ns += int'(stall_md);
         if (nb == abort_at) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_hi", HI, 0);
            check("rst_lo", LO, 0);
            void'(sb.pop_back());
            return;
         end
      end
      check("busy_cycles", nb, n);
      check("stall_cycles", ns, use_d ? n + 1 : 0);
      check("sb_size", sb.size(), 1);
      if (sb.size() > 0) check("hilo", {HI, LO}, sb.pop_front());
   endtask

   always @(negedge clk)
      if (busy && md_op_E != MD_NONE) check("op_in_busy", md_op_E, MD_NONE);

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] op;
      md_use_D = 1'b1;
      step();
      step();
      check("rst_state_busy", busy, 0);
      reset = 1'b0;
      check("rst_start", start, 0);
      check("rst_stall", stall_md, 0);
      check("rst_hi", HI, 0);
      check("rst_lo", LO, 0);
      md_op_E = MD_MFHI;
      #1;
      check("rst_mfhi", md_out_E, 0);
      md_op_E = MD_NONE;
      step();
      run_op(MD_MULT, 32'd3, 32'hFFFF_FFFE, MULT_CYCLES_DEF, 1'b1, 0);
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_CYCLES_DEF, 1'b0, 0);
      md_op_E = MD_MFLO;
      #1;
      check("mflo", md_out_E, 32'h1);
      md_op_E = MD_MFHI;
      #1;
      check("mfhi", md_out_E, 32'hFFFF_FFFE);
      md_op_E = MD_MTHI;
      A_E = 32'hDEAD_BEEF;
      step();
      md_op_E = MD_NONE;
      check("mthi_hi", HI, 32'hDEAD_BEEF);
      check("mthi_lo", LO, 32'h1);
      check("mthi_busy", busy, 0);
      md_op_E = MD_MTLO;
      A_E = 32'h55;
      md_use_D = 1'b1;
      #1;
      check("mtlo_start", start, 0);
      check("mtlo_stall", stall_md, 0);
      step();
      check("mtlo_lo", LO, 32'h55);
      check("mtlo_hi", HI, 32'hDEAD_BEEF);
      md_op_E = 4'hF;
      #1;
      check("op15_start", start, 0);
      check("op15_out", md_out_E, 0);
      step();
      md_op_E = MD_NONE;
      check("op15_busy", busy, 0);
      check("op15_hilo", {HI, LO}, {32'hDEAD_BEEF, 32'h55});
`ifdef MDU_DIV_EN
      run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, DIV_CYCLES_DEF, 1'b1, 0);
      run_op(MD_DIVU, 32'h1234, 32'h0, DIV_CYCLES_DEF, 1'b0, 0);
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYCLES_DEF, 1'b0, 0);
      run_op(MD_DIV, 32'hFFFF_FF9C, 32'd7, DIV_CYCLES_DEF, 1'b0, 0);
      md_op_E = MD_MTHI;
      A_E = 32'hABCD;
      step();
      md_op_E = MD_NONE;
      check("mthi2", HI, 32'hABCD);
      run_op(MD_DIV, 32'd100, 32'd3, DIV_CYCLES_DEF, 1'b1, 4);
`else
      md_op_E = MD_DIV;
      A_E = 32'd8;
      B_E = 32'd2;
      md_use_D = 1'b1;
      #1;
      check("nodiv_start", start, 0);
      check("nodiv_stall", stall_md, 0);
      step();
      md_op_E = MD_NONE;
      check("nodiv_busy", busy, 0);
      check("nodiv_hilo", {HI, LO}, {32'hDEAD_BEEF, 32'h55});
      run_op(MD_MULT, 32'd100, 32'd3, MULT_CYCLES_DEF, 1'b1, 4);
`endif
      step();
      for (int i = 0; i < 6; i++) begin
`ifdef MDU_DIV_EN
         op = 4'($urandom_range(1, 4));
`else
         op = 4'($urandom_range(1, 2));
`endif
         run_op(op, $urandom, (i == 5) ? 32'h0 : $urandom, is_mul(op) ? MULT_CYCLES_DEF : DIV_CYCLES_DEF,
                1'($urandom_range(0, 1)), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
